// File: rtl/xorshift_multi_stream.sv
// Multi-lane xorshift128 random source: LANES lock-step 32-bit generators behind a
// valid/ready output stream, with per-lane run-time reseeding and a post-seed warm-up.
module xorshift_multi_stream #(
    parameter int unsigned LANES        = 4,
    parameter int unsigned WARMUP_STEPS = 8,
    parameter logic [31:0] SEED_X       = 32'd123456789,
    parameter logic [31:0] SEED_Y       = 32'd362436069,
    parameter logic [31:0] SEED_Z       = 32'd521288629,
    parameter logic [31:0] SEED_W       = 32'd88675123,
    localparam int unsigned LW          = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  seed_valid,
    output logic                  seed_ready,
    input  logic [LW-1:0]         seed_lane,
    input  logic [127:0]          seed_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*LANES-1:0]   out_data
);

    localparam int unsigned CW = (WARMUP_STEPS > 0) ? $clog2(WARMUP_STEPS + 1) : 1;

    localparam logic [0:0] ST_WARMUP = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;
    localparam logic [0:0] ST_RESET  = (WARMUP_STEPS == 0) ? ST_RUN : ST_WARMUP;

    // Lane state packed as {x, y, z, w}
    function automatic logic [127:0] default_seed(input int unsigned lane);
        logic [31:0] k;
        k = 32'(lane * 32'h9E3779B9);
        return {SEED_X ^ k, SEED_Y ^ k, SEED_Z ^ k, SEED_W ^ k};
    endfunction

    function automatic logic [127:0] xs_step(input logic [127:0] s);
        logic [31:0] x, y, z, w, t;
        {x, y, z, w} = s;
        t = x ^ (x << 11);
        return {y, z, w, w ^ (w >> 19) ^ t ^ (t >> 8)};
    endfunction

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [127:0]  lane_q [LANES];
    logic [127:0]  lane_d [LANES];
    logic          fire_c;
    logic          seed_hit_c;
    logic          warm_step_c;
    logic          warm_done_c;

    assign fire_c      = out_valid && out_ready;
    assign seed_hit_c  = seed_valid && seed_ready && (32'(seed_lane) < LANES);
    assign warm_step_c = (state_q == ST_WARMUP) && (WARMUP_STEPS != 0);
    assign warm_done_c = (WARMUP_STEPS == 0) || ((32'(cnt_q) + 32'd1) >= WARMUP_STEPS);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WARMUP: begin
                if (warm_done_c) begin
                    state_d = ST_RUN;
                end else if (cnt_q != CW'(WARMUP_STEPS)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                if (seed_hit_c) begin
                    state_d = ST_WARMUP;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = '0;
            end
        endcase
    end

    // Seed beats stepping; the all-zero state is never allowed to persist
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_d[i] = lane_q[i];
            if (lane_q[i] == '0) begin
                lane_d[i] = default_seed(i);
            end else if (seed_hit_c && (32'(seed_lane) == i)) begin
                lane_d[i] = (seed_data == '0) ? default_seed(i) : seed_data;
            end else if (warm_step_c || fire_c) begin
                lane_d[i] = xs_step(lane_q[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_RESET;
            cnt_q      <= '0;
            out_valid  <= 1'b0;
            seed_ready <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) begin
                lane_q[i] <= default_seed(i);
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_valid  <= (state_d == ST_RUN);
            seed_ready <= (state_d == ST_RUN);
            for (int unsigned i = 0; i < LANES; i++) begin
                lane_q[i] <= lane_d[i];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            out_data[32*i +: 32] = lane_q[i][31:0];
        end
    end

endmodule
